// File: rtl/bcd_count_checker_if.sv
// Bundle between a BCD counter (or its driver) and bcd_count_checker.
// CHK_HOLD_EN adds the hold input (counter not stepping this cycle).
interface bcd_count_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             en;
    logic             ctrl;
    logic [WIDTH-1:0] q;
`ifdef CHK_HOLD_EN
    logic             hold;
`endif
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             wrap_up;
    logic             wrap_dn;
    logic [WIDTH-1:0] expected;

    modport master (
        output en, ctrl, q,
`ifdef CHK_HOLD_EN
        output hold,
`endif
        input  locked, err_pulse, err_cnt, wrap_up, wrap_dn, expected
    );

    modport slave (
        input  en, ctrl, q,
`ifdef CHK_HOLD_EN
        input  hold,
`endif
        output locked, err_pulse, err_cnt, wrap_up, wrap_dn, expected
    );
endinterface

// File: rtl/bcd_count_checker.sv
// Monitor for a BCD up/down counter: checks every enabled sample against the
// predicted next value. Optional feature macro: CHK_HOLD_EN (hold input).
module bcd_count_checker #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    bcd_count_checker_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    typedef enum logic {ACQUIRE, TRACK} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] qs_q;
    logic             cs_q;
    logic [WIDTH-1:0] expected_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_up_q;
    logic             wrap_dn_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic             in_range;
    logic [WIDTH-1:0] pred_d;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v, input logic up);
        if (up) return (v == MAXV) ? '0 : v + 1'b1;
        return (v == '0) ? MAXV : v - 1'b1;
    endfunction

    assign in_range  = (bus.q <= MAXV);
    assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    // A held counter must repeat its value; the prediction folds that in so the
    // compare below stays a single equality.
`ifdef CHK_HOLD_EN
    assign pred_d = bus.hold ? bus.q : nxt(bus.q, bus.ctrl);
`else
    assign pred_d = nxt(bus.q, bus.ctrl);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACQUIRE;
            qs_q        <= '0;
            cs_q        <= 1'b0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_dn_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_dn_q   <= 1'b0;
            if (bus.en) begin
                if (!in_range) begin
                    err_pulse_q <= 1'b1;
                    err_cnt_q   <= err_cnt_d;
                    locked_q    <= 1'b0;
                    expected_q  <= '0;
                    state_q     <= ACQUIRE;
                end else begin
                    // Step errors reseed from the bad sample, so a lone glitch costs two.
                    if (state_q == TRACK) begin
                        if (bus.q != expected_q) begin
                            err_pulse_q <= 1'b1;
                            err_cnt_q   <= err_cnt_d;
                        end else begin
                            wrap_up_q <= (qs_q == MAXV) &&  cs_q && (bus.q == '0);
                            wrap_dn_q <= (qs_q == '0)   && !cs_q && (bus.q == MAXV);
                        end
                    end
                    qs_q       <= bus.q;
                    cs_q       <= bus.ctrl;
                    expected_q <= pred_d;
                    locked_q   <= 1'b1;
                    state_q    <= TRACK;
                end
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.wrap_up   = wrap_up_q;
    assign bus.wrap_dn   = wrap_dn_q;
    assign bus.expected  = expected_q;
endmodule

// File: tb/tb_bcd_count_checker.sv
// Bench for bcd_count_checker: directed streams, a sample-history model checked
// every cycle, and hand-computed spot values. Two DUTs share stimulus (ERR_W 8 and 2).
module tb_bcd_count_checker;
    localparam int MAX = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold_v = 1'b0;
    logic chk_on = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bcd_count_checker_if #(.WIDTH(4), .ERR_W(8)) ifa ();
    bcd_count_checker_if #(.WIDTH(4), .ERR_W(2)) ifb ();

    assign ifb.en   = ifa.en;
    assign ifb.ctrl = ifa.ctrl;
    assign ifb.q    = ifa.q;
`ifdef CHK_HOLD_EN
    assign ifa.hold = hold_v;
    assign ifb.hold = hold_v;
`endif

    bcd_count_checker #(.WIDTH(4), .MAX(MAX), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    bcd_count_checker #(.WIDTH(4), .MAX(MAX), .ERR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: remembers the last in-range sample while locked and judges the
    // next one against the counting rule in modular arithmetic.
    int   m_errs, m_prevq;
    logic m_locked, m_prevc, m_prevh, m_errp, m_wu, m_wd;

    function automatic int nxt_m(input int v, input logic up);
        return up ? (v + 1) % (MAX + 1) : (v + MAX) % (MAX + 1);
    endfunction

    function automatic int legal_next();
        return m_prevh ? m_prevq : nxt_m(m_prevq, m_prevc);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_errs <= 0; m_prevq <= 0; m_locked <= 1'b0; m_prevc <= 1'b0;
            m_prevh <= 1'b0; m_errp <= 1'b0; m_wu <= 1'b0; m_wd <= 1'b0;
        end else begin
            m_errp <= 1'b0; m_wu <= 1'b0; m_wd <= 1'b0;
            if (ifa.en) begin
                if (int'(ifa.q) > MAX) begin
                    m_errp <= 1'b1; m_errs <= m_errs + 1; m_locked <= 1'b0;
                end else begin
                    if (m_locked && int'(ifa.q) != legal_next()) begin
                        m_errp <= 1'b1; m_errs <= m_errs + 1;
                    end else if (m_locked) begin
                        m_wu <= !m_prevh &&  m_prevc && m_prevq == MAX && ifa.q == 0;
                        m_wd <= !m_prevh && !m_prevc && m_prevq == 0   && int'(ifa.q) == MAX;
                    end
                    m_locked <= 1'b1; m_prevq <= int'(ifa.q); m_prevc <= ifa.ctrl; m_prevh <= hold_v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("locked",    int'(ifa.locked),    int'(m_locked));
            chk("err_pulse", int'(ifa.err_pulse), int'(m_errp));
            chk("wrap_up",   int'(ifa.wrap_up),   int'(m_wu));
            chk("wrap_dn",   int'(ifa.wrap_dn),   int'(m_wd));
            chk("expected",  int'(ifa.expected),  m_locked ? legal_next() : 0);
            chk("err_cnt",   int'(ifa.err_cnt),   (m_errs > 255) ? 255 : m_errs);
            chk("err_cnt_w2", int'(ifb.err_cnt),  (m_errs > 3) ? 3 : m_errs);
            chk("locked_w2", int'(ifb.locked),    int'(m_locked));
        end
    end

    // Drive one sample after the falling edge, return just after the capturing edge.
    task automatic smp(input logic e, input logic c, input int v, input logic h);
        @(negedge clk); #1;
        ifa.en = e; ifa.ctrl = c; ifa.q = 4'(v); hold_v = h;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1; ifa.en = 1'b0; hold_v = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        ifa.en = 1'b0; ifa.ctrl = 1'b0; ifa.q = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        chk_on = 1'b1;

        // Idle with en low: nothing may change.
        for (int i = 0; i < 5; i++) smp(1'b0, 1'b1, 11 + (i % 3), 1'b0);
        chk("t1_locked", int'(ifa.locked), 0);
        chk("t1_err_cnt", int'(ifa.err_cnt), 0);

        // Up count through the 9->0 wrap, with a disabled garbage cycle inside.
        do_reset();
        smp(1'b1, 1'b1, 0, 1'b0);
        chk("t2_locked", int'(ifa.locked), 1);
        chk("t2_expected", int'(ifa.expected), 1);
        for (int v = 1; v <= 9; v++) begin
            smp(1'b1, 1'b1, v, 1'b0);
            if (v == 5) smp(1'b0, 1'b0, 13, 1'b0);
        end
        smp(1'b1, 1'b1, 0, 1'b0);
        chk("t2_wrap_up", int'(ifa.wrap_up), 1);
        smp(1'b1, 1'b1, 1, 1'b0);
        chk("t2_wrap_up_clr", int'(ifa.wrap_up), 0);
        chk("t2_err_cnt", int'(ifa.err_cnt), 0);

        // Down count through 0->9, preceded by a legal direction change.
        do_reset();
        smp(1'b1, 1'b1, 3, 1'b0);
        smp(1'b1, 1'b0, 4, 1'b0);
        chk("t3_expected_dn", int'(ifa.expected), 3);
        for (int v = 3; v >= 0; v--) smp(1'b1, 1'b0, v, 1'b0);
        smp(1'b1, 1'b0, 9, 1'b0);
        chk("t3_wrap_dn", int'(ifa.wrap_dn), 1);
        smp(1'b1, 1'b0, 8, 1'b0);
        chk("t3_wrap_dn_clr", int'(ifa.wrap_dn), 0);
        chk("t3_err_cnt", int'(ifa.err_cnt), 0);

        // Skipped value, then a single glitched sample.
        do_reset();
        smp(1'b1, 1'b1, 3, 1'b0);
        smp(1'b1, 1'b1, 4, 1'b0);
        smp(1'b1, 1'b1, 6, 1'b0);
        chk("t4_err_pulse", int'(ifa.err_pulse), 1);
        chk("t4_err_cnt", int'(ifa.err_cnt), 1);
        chk("t4_locked", int'(ifa.locked), 1);
        chk("t4_expected7", int'(ifa.expected), 7);
        smp(1'b1, 1'b1, 7, 1'b0);
        chk("t4_expected8", int'(ifa.expected), 8);
        chk("t4_pulse_clr", int'(ifa.err_pulse), 0);
        smp(1'b1, 1'b1, 8, 1'b0);
        do_reset();
        smp(1'b1, 1'b1, 3, 1'b0);
        smp(1'b1, 1'b1, 4, 1'b0);
        smp(1'b1, 1'b1, 7, 1'b0);
        smp(1'b1, 1'b1, 5, 1'b0);
        smp(1'b1, 1'b1, 6, 1'b0);
        chk("t4_glitch_cnt", int'(ifa.err_cnt), 2);
        chk("t4_glitch_pulse", int'(ifa.err_pulse), 0);

        // Range errors, reacquire, then saturation on the narrow counter.
        do_reset();
        smp(1'b1, 1'b1, 2, 1'b0);
        smp(1'b1, 1'b1, 3, 1'b0);
        smp(1'b1, 1'b1, 12, 1'b0);
        chk("t5_err_pulse", int'(ifa.err_pulse), 1);
        chk("t5_locked", int'(ifa.locked), 0);
        chk("t5_expected0", int'(ifa.expected), 0);
        smp(1'b1, 1'b1, 5, 1'b0);
        chk("t5_relock", int'(ifa.locked), 1);
        chk("t5_expected6", int'(ifa.expected), 6);
        do_reset();
        for (int i = 0; i < 5; i++) smp(1'b1, 1'b1, 10 + i, 1'b0);
        chk("t5_sat_w2", int'(ifb.err_cnt), 3);
        chk("t5_cnt_w8", int'(ifa.err_cnt), 5);
        chk("t5_sat_pulse", int'(ifb.err_pulse), 1);

        // Asynchronous reset between edges.
        do_reset();
        smp(1'b1, 1'b1, 3, 1'b0);
        smp(1'b1, 1'b1, 5, 1'b0);
        chk("t6_pre_err", int'(ifa.err_cnt), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_locked", int'(ifa.locked), 0);
        chk("t6_rst_err_cnt", int'(ifa.err_cnt), 0);
        chk("t6_rst_expected", int'(ifa.expected), 0);
        chk("t6_rst_pulse", int'(ifa.err_pulse), 0);
        @(negedge clk); #2 rst = 1'b0;

        do_reset();
`ifdef CHK_HOLD_EN
        smp(1'b1, 1'b1, 4, 1'b1);
        smp(1'b1, 1'b1, 4, 1'b0);
        smp(1'b1, 1'b1, 5, 1'b0);
        chk("t6_hold_err", int'(ifa.err_cnt), 0);
`else
        smp(1'b1, 1'b1, 4, 1'b0);
        smp(1'b1, 1'b1, 4, 1'b0);
        chk("t6_repeat_err", int'(ifa.err_cnt), 1);
`endif
        smp(1'b0, 1'b0, 0, 1'b0);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
